// File: rtl/ball_frame_scheduler.sv
// Shadow bank of ball positions and screen state, committed atomically to the
// display-side buses on the end-of-frame boundary or when the commit times out.
//
// state | meaning
// IDLE  | writes accepted into the shadow bank; waiting for a commit request
// PEND  | commit requested; writes stalled until iEndFrame or timeout applies the bank
module ball_frame_scheduler #(
   parameter int NUM_BALLS = 11,
   parameter int TIMEOUT   = 1_000_000
) (
   input  logic                   iCLK,
   input  logic                   iRST_n,
   input  logic                   iWrValid,
   output logic                   oWrReady,
   input  logic [3:0]             iWrIdx,
   input  logic [9:0]             iWrX,
   input  logic [8:0]             iWrY,
   input  logic                   iPlayer,
   input  logic [2:0]             iScreenType,
   input  logic                   iCommit,
   input  logic                   iEndFrame,
   output logic                   oCommitPending,
   output logic                   oCommitDone,
   output logic                   oTimeout,
   output logic                   oIdxErr,
   output logic [NUM_BALLS*10-1:0] oX,
   output logic [NUM_BALLS*9-1:0]  oY,
   output logic                   oPlayer,
   output logic [2:0]             oScreenType,
   output logic [15:0]            oFrameCnt
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [4:0] NB5 = 5'(NUM_BALLS);

   typedef enum logic {IDLE, PEND} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NUM_BALLS*10-1:0] shx_q, shx_d, outx_q, outx_d;
   logic [NUM_BALLS*9-1:0]  shy_q, shy_d, outy_q, outy_d;
   logic                    stg_p_q, stg_p_d, outp_q, outp_d;
   logic [2:0]              stg_s_q, stg_s_d, outs_q, outs_d;
   logic                    done_q, done_d, to_q, to_d, ierr_q, ierr_d;
   logic [15:0]             fc_q, fc_d;
   logic                    idx_ok;

   assign idx_ok = ({1'b0, iWrIdx} < NB5);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shx_d   = shx_q;
      shy_d   = shy_q;
      stg_p_d = stg_p_q;
      stg_s_d = stg_s_q;
      outx_d  = outx_q;
      outy_d  = outy_q;
      outp_d  = outp_q;
      outs_d  = outs_q;
      done_d  = 1'b0;
      to_d    = 1'b0;
      ierr_d  = 1'b0;
      fc_d    = iEndFrame ? fc_q + 16'd1 : fc_q;

      case (state_q)
         IDLE: begin
            if (iWrValid) begin
               if (idx_ok) begin
                  for (int i = 0; i < NUM_BALLS; i++) begin
                     if (iWrIdx == 4'(i)) begin
                        shx_d[i*10 +: 10] = iWrX;
                        shy_d[i*9 +: 9]   = iWrY;
                     end
                  end
               end else begin
                  ierr_d = 1'b1;
               end
            end
            // An end-of-frame in the commit cycle is deliberately not an apply
            if (iCommit) begin
               stg_p_d = iPlayer;
               stg_s_d = iScreenType;
               cnt_d   = '0;
               state_d = PEND;
            end
         end
         PEND: begin
            if (iEndFrame || (cnt_q == CNT_LAST)) begin
               outx_d  = shx_q;
               outy_d  = shy_q;
               outp_d  = stg_p_q;
               outs_d  = stg_s_q;
               done_d  = 1'b1;
               to_d    = ~iEndFrame;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shx_q   <= '0;
         shy_q   <= '0;
         stg_p_q <= 1'b0;
         stg_s_q <= '0;
         outx_q  <= '0;
         outy_q  <= '0;
         outp_q  <= 1'b0;
         outs_q  <= '0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
         ierr_q  <= 1'b0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shx_q   <= shx_d;
         shy_q   <= shy_d;
         stg_p_q <= stg_p_d;
         stg_s_q <= stg_s_d;
         outx_q  <= outx_d;
         outy_q  <= outy_d;
         outp_q  <= outp_d;
         outs_q  <= outs_d;
         done_q  <= done_d;
         to_q    <= to_d;
         ierr_q  <= ierr_d;
         fc_q    <= fc_d;
      end
   end

   assign oWrReady       = (state_q == IDLE);
   assign oCommitPending = (state_q == PEND);
   assign oCommitDone    = done_q;
   assign oTimeout       = to_q;
   assign oIdxErr        = ierr_q;
   assign oX             = outx_q;
   assign oY             = outy_q;
   assign oPlayer        = outp_q;
   assign oScreenType    = outs_q;
   assign oFrameCnt      = fc_q;

endmodule

// File: tb/tb_ball_frame_scheduler.sv
// Bench for ball_frame_scheduler: two instances (long and short timeout) on shared
// stimulus, compared every cycle against a frame-level reference model.
module tb_ball_frame_scheduler;

   localparam int NB = 11;

   logic iCLK = 1'b0;
   logic iRST_n;
   logic iWrValid, iPlayer, iCommit, iEndFrame;
   logic [3:0] iWrIdx;
   logic [9:0] iWrX;
   logic [8:0] iWrY;
   logic [2:0] iScreenType;

   logic [1:0] rdy, pend, done, tout, ierr, opl;
   logic [NB*10-1:0] ox0, ox1;
   logic [NB*9-1:0]  oy0, oy1;
   logic [2:0]  ost0, ost1;
   logic [15:0] fc0, fc1;

   int vecs = 0;
   int miss = 0;

   always #5 iCLK = ~iCLK;

   ball_frame_scheduler #(.NUM_BALLS(NB), .TIMEOUT(1000)) dut_long (
      .iCLK(iCLK), .iRST_n(iRST_n), .iWrValid(iWrValid), .oWrReady(rdy[0]),
      .iWrIdx(iWrIdx), .iWrX(iWrX), .iWrY(iWrY), .iPlayer(iPlayer),
      .iScreenType(iScreenType), .iCommit(iCommit), .iEndFrame(iEndFrame),
      .oCommitPending(pend[0]), .oCommitDone(done[0]), .oTimeout(tout[0]),
      .oIdxErr(ierr[0]), .oX(ox0), .oY(oy0), .oPlayer(opl[0]),
      .oScreenType(ost0), .oFrameCnt(fc0));

   ball_frame_scheduler #(.NUM_BALLS(NB), .TIMEOUT(16)) dut_short (
      .iCLK(iCLK), .iRST_n(iRST_n), .iWrValid(iWrValid), .oWrReady(rdy[1]),
      .iWrIdx(iWrIdx), .iWrX(iWrX), .iWrY(iWrY), .iPlayer(iPlayer),
      .iScreenType(iScreenType), .iCommit(iCommit), .iEndFrame(iEndFrame),
      .oCommitPending(pend[1]), .oCommitDone(done[1]), .oTimeout(tout[1]),
      .oIdxErr(ierr[1]), .oX(ox1), .oY(oy1), .oPlayer(opl[1]),
      .oScreenType(ost1), .oFrameCnt(fc1));

   // Reference model: per instance, a pending flag plus the number of the PEND
   // cycle currently running; the bank is applied when a frame ends or when the
   // PEND cycle number reaches the timeout length.
   int         to_len [2] = '{1000, 16};
   bit         m_pend [2];
   int         m_age  [2];
   logic [9:0] m_sx [2][NB];
   logic [8:0] m_sy [2][NB];
   logic [9:0] m_ox [2][NB];
   logic [8:0] m_oy [2][NB];
   logic       m_sp [2], m_op [2];
   logic [2:0] m_ss [2], m_os [2];
   bit         m_done [2], m_to [2], m_ierr [2];
   int         m_fc [2];

   task automatic mreset(input int i);
      m_pend[i] = 0; m_age[i] = 0;
      for (int j = 0; j < NB; j++) begin
         m_sx[i][j] = '0; m_sy[i][j] = '0; m_ox[i][j] = '0; m_oy[i][j] = '0;
      end
      m_sp[i] = 0; m_op[i] = 0; m_ss[i] = '0; m_os[i] = '0;
      m_done[i] = 0; m_to[i] = 0; m_ierr[i] = 0; m_fc[i] = 0;
   endtask

   task automatic mstep(input int i);
      m_done[i] = 0; m_to[i] = 0; m_ierr[i] = 0;
      if (iEndFrame) m_fc[i] = (m_fc[i] + 1) % 65536;
      if (!m_pend[i]) begin
         if (iWrValid) begin
            if (int'(iWrIdx) < NB) begin
               m_sx[i][iWrIdx] = iWrX;
               m_sy[i][iWrIdx] = iWrY;
            end else m_ierr[i] = 1;
         end
         if (iCommit) begin
            m_sp[i] = iPlayer; m_ss[i] = iScreenType;
            m_pend[i] = 1; m_age[i] = 1;
         end
      end else if (iEndFrame || m_age[i] == to_len[i]) begin
         m_ox[i] = m_sx[i]; m_oy[i] = m_sy[i];
         m_op[i] = m_sp[i]; m_os[i] = m_ss[i];
         m_done[i] = 1; m_to[i] = !iEndFrame; m_pend[i] = 0;
      end else m_age[i]++;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_inst(input int i, input logic r, input logic p, input logic d,
                             input logic t, input logic e, input logic [NB*10-1:0] x,
                             input logic [NB*9-1:0] y, input logic pl, input logic [2:0] st,
                             input logic [15:0] fc);
      logic [NB*10-1:0] ex;
      logic [NB*9-1:0]  ey;
      for (int j = 0; j < NB; j++) begin
         ex[j*10 +: 10] = m_ox[i][j];
         ey[j*9 +: 9]   = m_oy[i][j];
      end
      chk($sformatf("wr_ready%0d", i), 128'(r), 128'(!m_pend[i]));
      chk($sformatf("pending%0d", i), 128'(p), 128'(m_pend[i]));
      chk($sformatf("done%0d", i), 128'(d), 128'(m_done[i]));
      chk($sformatf("timeout%0d", i), 128'(t), 128'(m_to[i]));
      chk($sformatf("idxerr%0d", i), 128'(e), 128'(m_ierr[i]));
      chk($sformatf("x%0d", i), 128'(x), 128'(ex));
      chk($sformatf("y%0d", i), 128'(y), 128'(ey));
      chk($sformatf("player%0d", i), 128'(pl), 128'(m_op[i]));
      chk($sformatf("screen%0d", i), 128'(st), 128'(m_os[i]));
      chk($sformatf("framecnt%0d", i), 128'(fc), 128'(m_fc[i]));
   endtask

   task automatic check_all();
      check_inst(0, rdy[0], pend[0], done[0], tout[0], ierr[0], ox0, oy0, opl[0], ost0, fc0);
      check_inst(1, rdy[1], pend[1], done[1], tout[1], ierr[1], ox1, oy1, opl[1], ost1, fc1);
   endtask

   task automatic tick(input bit do_chk = 1'b1);
      @(posedge iCLK);
      for (int i = 0; i < 2; i++) begin
         if (!iRST_n) mreset(i); else mstep(i);
      end
      #1;
      if (do_chk) check_all();
   endtask

   task automatic idle_inputs();
      iWrValid = 0; iCommit = 0; iEndFrame = 0;
   endtask

   task automatic wr(input int idx, input int x, input int y);
      iWrValid = 1; iWrIdx = 4'(idx); iWrX = 10'(x); iWrY = 9'(y);
      tick();
      iWrValid = 0;
   endtask

   initial begin
      iRST_n = 0; iWrIdx = '0; iWrX = '0; iWrY = '0; iPlayer = 0; iScreenType = '0;
      idle_inputs();
      mreset(0); mreset(1);
      #23;
      @(negedge iCLK) iRST_n = 1;
      for (int k = 0; k < 5; k++) tick();
      chk("reset_ready", 128'(rdy[0]), 128'(1'b1));
      chk("reset_x", 128'(ox0), 128'(0));

      // Atomic commit with a late end-of-frame
      wr(3, 512, 300);
      wr(10, 799, 479);
      iPlayer = 1; iScreenType = 3'd5; iCommit = 1;
      tick();
      iCommit = 0; iPlayer = 0; iScreenType = '0;
      for (int k = 0; k < 199; k++) tick();
      chk("atomic_hold_x3", 128'(ox0[30 +: 10]), 128'(0));
      iEndFrame = 1;
      tick();
      iEndFrame = 0;
      chk("atomic_x3", 128'(ox0[30 +: 10]), 128'(512));
      chk("atomic_y3", 128'(oy0[27 +: 9]), 128'(300));
      chk("atomic_x10", 128'(ox0[100 +: 10]), 128'(799));
      chk("atomic_y10", 128'(oy0[90 +: 9]), 128'(479));
      chk("atomic_screen", 128'(ost0), 128'(5));
      chk("atomic_done", 128'(done[0]), 128'(1'b1));
      tick();
      chk("atomic_done_pulse", 128'(done[0]), 128'(1'b0));

      // Writes held during PEND must stall and not reach the bank
      iCommit = 1; tick(); iCommit = 0;
      iWrValid = 1; iWrIdx = 4'd3; iWrX = 10'd5; iWrY = 9'd5;
      for (int k = 0; k < 5; k++) tick();
      chk("stall_ready", 128'(rdy[0]), 128'(1'b0));
      iWrValid = 0; iEndFrame = 1; tick(); iEndFrame = 0;
      chk("stall_bank", 128'(ox0[30 +: 10]), 128'(512));

      // Commit coinciding with end-of-frame waits for the next one
      iCommit = 1; iEndFrame = 1; tick(); iCommit = 0; iEndFrame = 0;
      chk("coinc_pending", 128'(pend[0]), 128'(1'b1));
      chk("coinc_no_done", 128'(done[0]), 128'(1'b0));
      for (int k = 0; k < 3; k++) tick();
      iEndFrame = 1; tick(); iEndFrame = 0;
      chk("coinc_done", 128'(done[0]), 128'(1'b1));

      // Out-of-range slot
      wr(11, 100, 7);
      chk("idxerr_pulse", 128'(ierr[0]), 128'(1'b1));
      tick();
      chk("idxerr_once", 128'(ierr[0]), 128'(1'b0));
      iCommit = 1; tick(); iCommit = 0;
      iEndFrame = 1; tick(); iEndFrame = 0;
      tick();

      // Short-timeout instance: forced apply, then end-of-frame on the last cycle
      iCommit = 1; tick(); iCommit = 0;
      for (int k = 0; k < 15; k++) tick();
      chk("to_early", 128'(done[1]), 128'(1'b0));
      tick();
      chk("to_flag", 128'(tout[1]), 128'(1'b1));
      chk("to_done", 128'(done[1]), 128'(1'b1));
      iEndFrame = 1; tick(); iEndFrame = 0;
      tick();
      iCommit = 1; tick(); iCommit = 0;
      for (int k = 0; k < 15; k++) tick();
      iEndFrame = 1; tick(); iEndFrame = 0;
      chk("to_coinc_flag", 128'(tout[1]), 128'(1'b0));
      chk("to_coinc_done", 128'(done[1]), 128'(1'b1));
      tick();

      // Randomized traffic
      for (int k = 0; k < 800; k++) begin
         iWrValid    = 1'($urandom_range(0, 1));
         iWrIdx      = 4'($urandom_range(0, 15));
         iWrX        = 10'($urandom);
         iWrY        = 9'($urandom);
         iPlayer     = 1'($urandom);
         iScreenType = 3'($urandom);
         iCommit     = ($urandom_range(0, 7) == 0);
         iEndFrame   = ($urandom_range(0, 11) == 0);
         tick();
      end
      idle_inputs();
      tick();

      // Frame counter wrap from reset
      iRST_n = 0; tick(1'b0); iRST_n = 1; tick();
      iEndFrame = 1;
      for (int k = 0; k < 65537; k++) tick(1'b0);
      iEndFrame = 0;
      tick();
      chk("frame_wrap", 128'(fc0), 128'(16'd1));

      // Asynchronous reset in the middle of PEND
      wr(4, 321, 123);
      iCommit = 1; tick(); iCommit = 0;
      for (int k = 0; k < 3; k++) tick();
      #2 iRST_n = 0;
      mreset(0); mreset(1);
      #1;
      check_all();
      chk("async_pending", 128'(pend[0]), 128'(1'b0));
      tick(); tick();
      @(negedge iCLK) iRST_n = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("async_no_done", 128'(done[0]), 128'(1'b0));
      end
      iEndFrame = 1; tick(); iEndFrame = 0;
      tick();
      chk("async_bank_cleared", 128'(ox0[40 +: 10]), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/ball_frame_scheduler.md
Name: ball_frame_scheduler

Overview:
- Stages ball positions and screen state written by the game logic into a shadow bank.
- Commits the whole bank atomically to the display-side position buses on the end-of-frame boundary, so a frame never shows a mix of old and new positions.
- Sits between the game/SPI logic and mtl_display_controller's iX/iY, player and screenType inputs.
- Also counts frames and enforces a commit timeout.

Parameters:
- NUM_BALLS, 11, number of ball slots (index 0..NUM_BALLS-1).
- TIMEOUT, 1_000_000, iCLK cycles a pending commit waits for iEndFrame before forcing the commit.

Ports:
- iCLK  in  1  system clock; the only clock.
- iRST_n  in  1  asynchronous active-low reset.
- iWrValid  in  1  shadow write request.
- oWrReady  out  1  write accepted when iWrValid&&oWrReady at a rising edge.
- iWrIdx  in  4  ball slot index.
- iWrX  in  10  x position.
- iWrY  in  9  y position.
- iPlayer  in  1  player flag, sampled at commit request.
- iScreenType  in  3  screen type, sampled at commit request.
- iCommit  in  1  request an atomic commit of the shadow bank.
- iEndFrame  in  1  end-of-frame pulse, already synchronous to iCLK, 1 cycle wide.
- oCommitPending  out  1  commit requested, not yet applied.
- oCommitDone  out  1  1-cycle pulse after the bank is applied.
- oTimeout  out  1  1-cycle pulse when the commit was forced by the timeout.
- oIdxErr  out  1  1-cycle pulse when an accepted write had iWrIdx>=NUM_BALLS.
- oX  out  NUM_BALLS*10  live x bus; slot i at [i*10+:10].
- oY  out  NUM_BALLS*9  live y bus; slot i at [i*9+:9].
- oPlayer  out  1  live player flag.
- oScreenType  out  3  live screen type.
- oFrameCnt  out  16  count of iEndFrame pulses.

Behaviour:
- Reset (iRST_n low, asynchronous): the following clear to 0:
  - shadow bank, oX, oY, oPlayer, oScreenType, oFrameCnt;
  - oCommitPending, oCommitDone, oTimeout, oIdxErr;
  - timeout counter.
- Reset state: state=IDLE; oWrReady=1 the first cycle after release.
- Reset mid-commit discards the pending commit and clears the shadow bank.
- FSM states IDLE and PEND, registered; oWrReady=(state==IDLE); oCommitPending=(state==PEND).
- IDLE behaviour:
  - An accepted write with iWrIdx<NUM_BALLS updates shadow[iWrIdx] at that edge.
  - An accepted write with iWrIdx>=NUM_BALLS is dropped, and oIdxErr=1 the next cycle.
  - Writes to the same slot: last write wins.
- IDLE with iCommit=1:
  - Latch iPlayer and iScreenType into staging registers.
  - Go to PEND; clear the timeout counter.
  - A write accepted in the same cycle as iCommit is included in the commit.
- IDLE with iCommit and iEndFrame in the same cycle: go to PEND and wait for the NEXT iEndFrame; no same-cycle apply.
- PEND: iWrValid is stalled (oWrReady=0), iCommit is ignored, and the timeout counter increments every cycle.
- PEND with iEndFrame=1 at an edge:
  - At that edge, oX/oY take the shadow bank, and oPlayer/oScreenType take the staging registers.
  - oCommitDone=1 for the following cycle; state returns to IDLE.
  - Apply latency: outputs change 1 cycle after iEndFrame is sampled.
- PEND timeout: when the counter reaches TIMEOUT-1 with no iEndFrame, apply identically at the next edge; oTimeout=1 and oCommitDone=1 for one cycle.
- If iEndFrame coincides with the timeout: treat it as a normal apply; oTimeout stays 0.
- oX/oY/oPlayer/oScreenType change only on an apply edge; at all other times they hold.
- oFrameCnt increments on every sampled iEndFrame in any state and wraps 0xFFFF to 0x0000.
- All outputs are registered; there are no combinational paths from inputs to outputs except via oWrReady (derived from state only).

Test Plan:
- Reset release: after 5 cycles -> oWrReady=1, oX=0, oY=0, oFrameCnt=0, oCommitPending=0.
- Atomic commit:
  - Stimulus: write idx3 x=512 y=300 and idx10 x=799 y=479, iCommit, then iEndFrame 200 cycles later.
  - Required: oX/oY unchanged until 1 cycle after iEndFrame; then oX[30+:10]=512, oY[27+:9]=300, oX[100+:10]=799, oY[90+:9]=479; oCommitDone 1 cycle.
- Stall and coincidence:
  - iWrValid held in PEND -> oWrReady=0 and the shadow bank is unchanged.
  - iCommit and iEndFrame in the same cycle in IDLE -> no apply until the second iEndFrame.
- Bad index: write idx=11 x=100 -> oIdxErr pulses once; shadow and outputs unchanged after a later commit.
- Timeout:
  - Stimulus: TIMEOUT=16, iCommit, no iEndFrame.
  - Required: apply at the 16th PEND cycle with oTimeout=1 and oCommitDone=1; with iEndFrame on that same cycle, oTimeout=0.
- Frame counter and async reset:
  - 65537 iEndFrame pulses -> oFrameCnt=1.
  - iRST_n low mid-PEND -> immediate clear; no oCommitDone after release.
